// File: rtl/wb_pkg.sv
// Shared types and default sizes for the writeback commit queue.
// Optional forwarding lookup is enabled by defining WB_COMMIT_FWD_EN.
package wb_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;

    // One queued register write at default widths.
    typedef struct packed {
        logic [WB_AW-1:0] dest;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo_mem.sv
// Entry storage and read/write pointers for the writeback queue.
// Lookup taps (pointer and full array) exist only with WB_COMMIT_FWD_EN.
module wb_fifo_mem
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int W     = WB_AW + WB_DW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_wr_en,
    input  logic [W-1:0]            i_wr_data,
    input  logic                    i_rd_en,
    output logic [W-1:0]            o_rd_data
`ifdef WB_COMMIT_FWD_EN
    ,
    output logic [PW-1:0]           o_rd_ptr,
    output logic [DEPTH-1:0][W-1:0] o_mem
`endif
);

    logic [DEPTH-1:0][W-1:0] r_mem;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;

    // Storage write; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; clear drops everything queued.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

`ifdef WB_COMMIT_FWD_EN
    assign o_rd_ptr = r_rd_ptr;
    assign o_mem    = r_mem;
`endif

endmodule

// File: rtl/wb_commit_queue.sv
// Writeback commit queue: buffers ALU results and retires one per cycle.
// Define WB_COMMIT_FWD_EN to add the lk_* pending-write lookup ports.
module wb_commit_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_dest,
    input  logic [DW-1:0] in_data,
    input  logic          flush,
    output logic [AW-1:0] wb_dest,
    output logic [DW-1:0] wb_data,
    output logic          wb_en,
    output logic          busy
`ifdef WB_COMMIT_FWD_EN
    ,
    input  logic [AW-1:0] lk_reg,
    output logic          lk_hit,
    output logic [DW-1:0] lk_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + DW;

    logic [PW:0]     r_count;
    logic            r_wb_en;
    logic [AW-1:0]   r_wb_dest;
    logic [DW-1:0]   r_wb_data;

    logic            w_push;
    logic            w_store;
    logic            w_pop;
    logic [EW-1:0]   w_head;

    assign in_ready = (r_count != (PW+1)'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_store  = w_push && (in_dest != '0);
    assign w_pop    = (r_count != '0);

`ifdef WB_COMMIT_FWD_EN
    logic [PW-1:0]            w_rd_ptr;
    logic [DEPTH-1:0][EW-1:0] w_mem;
`endif

    wb_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW),
        .PW    (PW)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (flush),
        .i_wr_en   (w_store && !flush),
        .i_wr_data ({in_dest, in_data}),
        .i_rd_en   (w_pop && !flush),
        .o_rd_data (w_head)
`ifdef WB_COMMIT_FWD_EN
        ,
        .o_rd_ptr  (w_rd_ptr),
        .o_mem     (w_mem)
`endif
    );

    // Occupancy and the registered bank write port; flush cancels issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_wb_en   <= 1'b0;
            r_wb_dest <= '0;
            r_wb_data <= '0;
        end else if (flush) begin
            r_count   <= '0;
            r_wb_en   <= 1'b0;
        end else begin
            r_count <= r_count + (PW+1)'(w_store) - (PW+1)'(w_pop);
            r_wb_en <= w_pop;
            if (w_pop) begin
                r_wb_dest <= w_head[EW-1 -: AW];
                r_wb_data <= w_head[DW-1:0];
            end
        end
    end

    assign wb_en   = r_wb_en;
    assign wb_dest = r_wb_dest;
    assign wb_data = r_wb_data;
    assign busy    = (r_count != '0) || r_wb_en;

`ifdef WB_COMMIT_FWD_EN
    logic          w_hit;
    logic [DW-1:0] w_ldata;
    logic [PW-1:0] w_idx;

    // Youngest match wins: in-flight first, then queue oldest to newest.
    always_comb begin
        w_hit   = 1'b0;
        w_ldata = '0;
        w_idx   = '0;
        if (lk_reg != '0) begin
            if (r_wb_en && (r_wb_dest == lk_reg)) begin
                w_hit   = 1'b1;
                w_ldata = r_wb_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                w_idx = w_rd_ptr + PW'(i);
                if (((PW+1)'(i) < r_count) &&
                    (w_mem[w_idx][EW-1 -: AW] == lk_reg)) begin
                    w_hit   = 1'b1;
                    w_ldata = w_mem[w_idx][DW-1:0];
                end
            end
        end
    end

    assign lk_hit  = w_hit;
    assign lk_data = w_ldata;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed table-driven bench for wb_commit_queue.
// Lookup checks are compiled in when WB_COMMIT_FWD_EN is defined.
module tb_wb_commit_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dest;
    logic [31:0] in_data;
    logic        flush;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_en;
    logic        busy;
`ifdef WB_COMMIT_FWD_EN
    logic [4:0]  lk_reg;
    logic        lk_hit;
    logic [31:0] lk_data;
`endif

    int n_vec;
    int n_err;

    wb_commit_queue dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dest  (in_dest),
        .in_data  (in_data),
        .flush    (flush),
        .wb_dest  (wb_dest),
        .wb_data  (wb_data),
        .wb_en    (wb_en),
        .busy     (busy)
`ifdef WB_COMMIT_FWD_EN
        ,
        .lk_reg   (lk_reg),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [4:0]  d;
        logic [31:0] dat;
        logic        f;
        logic        rdy;
        logic        en;
        logic [4:0]  wd;
        logic [31:0] wdat;
        logic        bsy;
    } vec_t;

    localparam int NV = 27;
    vec_t tv [NV];

    function automatic vec_t mk(logic r, logic v, logic [4:0] d,
                                logic [31:0] dat, logic f, logic rdy,
                                logic en, logic [4:0] wd,
                                logic [31:0] wdat, logic bsy);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.dat = dat; t.f = f;
        t.rdy = rdy; t.en = en; t.wd = wd; t.wdat = wdat; t.bsy = bsy;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(logic r, logic v, logic [4:0] d,
                         logic [31:0] dat, logic f);
        @(negedge clk);
        rst = r; in_valid = v; in_dest = d; in_data = dat; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0;
        flush = 1'b0;
`ifdef WB_COMMIT_FWD_EN
        lk_reg = '0;
`endif
        //          rst v  d   data   f   rdy en wd  wdata  busy
        tv[0]  = mk(1, 0, 0,  32'h0,  0,  1, 0, 0,  32'h0,  0);
        tv[1]  = mk(0, 1, 3,  32'h55, 0,  1, 0, 0,  32'h0,  1);
        tv[2]  = mk(0, 0, 0,  32'h0,  0,  1, 1, 3,  32'h55, 1);
        tv[3]  = mk(0, 0, 0,  32'h0,  0,  1, 0, 3,  32'h55, 0);
        tv[4]  = mk(0, 1, 1,  32'h11, 0,  1, 0, 3,  32'h55, 1);
        tv[5]  = mk(0, 1, 2,  32'h22, 0,  1, 1, 1,  32'h11, 1);
        tv[6]  = mk(0, 1, 3,  32'h33, 0,  1, 1, 2,  32'h22, 1);
        tv[7]  = mk(0, 1, 4,  32'h44, 0,  1, 1, 3,  32'h33, 1);
        tv[8]  = mk(0, 1, 5,  32'h55, 0,  1, 1, 4,  32'h44, 1);
        tv[9]  = mk(0, 0, 0,  32'h0,  0,  1, 1, 5,  32'h55, 1);
        tv[10] = mk(0, 0, 0,  32'h0,  0,  1, 0, 5,  32'h55, 0);
        tv[11] = mk(0, 1, 0,  32'hFF, 0,  1, 0, 5,  32'h55, 0);
        tv[12] = mk(0, 1, 2,  32'h22, 0,  1, 0, 5,  32'h55, 1);
        tv[13] = mk(0, 0, 0,  32'h0,  0,  1, 1, 2,  32'h22, 1);
        tv[14] = mk(0, 0, 0,  32'h0,  0,  1, 0, 2,  32'h22, 0);
        tv[15] = mk(0, 1, 6,  32'h66, 0,  1, 0, 2,  32'h22, 1);
        tv[16] = mk(0, 1, 7,  32'h77, 0,  1, 1, 6,  32'h66, 1);
        tv[17] = mk(0, 1, 8,  32'h88, 0,  1, 1, 7,  32'h77, 1);
        tv[18] = mk(0, 1, 9,  32'h99, 1,  1, 0, 7,  32'h77, 0);
        tv[19] = mk(0, 0, 0,  32'h0,  0,  1, 0, 7,  32'h77, 0);
        tv[20] = mk(0, 1, 10, 32'hA0, 0,  1, 0, 7,  32'h77, 1);
        tv[21] = mk(0, 1, 11, 32'hB0, 0,  1, 1, 10, 32'hA0, 1);
        tv[22] = mk(1, 1, 12, 32'hC0, 0,  1, 0, 0,  32'h0,  0);
        tv[23] = mk(0, 0, 0,  32'h0,  0,  1, 0, 0,  32'h0,  0);
        tv[24] = mk(0, 1, 13, 32'hD0, 0,  1, 0, 0,  32'h0,  1);
        tv[25] = mk(0, 0, 0,  32'h0,  0,  1, 1, 13, 32'hD0, 1);
        tv[26] = mk(0, 0, 0,  32'h0,  0,  1, 0, 13, 32'hD0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].rst, tv[i].v, tv[i].d, tv[i].dat, tv[i].f);
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(tv[i].rdy));
            chk($sformatf("v%0d.wb_en", i), 32'(wb_en), 32'(tv[i].en));
            chk($sformatf("v%0d.wb_dest", i), 32'(wb_dest), 32'(tv[i].wd));
            chk($sformatf("v%0d.wb_data", i), wb_data, tv[i].wdat);
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tv[i].bsy));
        end

        // Sustained 6-cycle burst: never stalls, retires in order.
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 5'(16 + i), 32'(256 + i), 0);
            chk($sformatf("burst%0d.in_ready", i), 32'(in_ready), 32'd1);
            if (i > 0) begin
                chk($sformatf("burst%0d.wb_en", i), 32'(wb_en), 32'd1);
                chk($sformatf("burst%0d.wb_dest", i), 32'(wb_dest),
                    32'(15 + i));
                chk($sformatf("burst%0d.wb_data", i), wb_data,
                    32'(255 + i));
            end
        end
        drive(0, 0, 0, 0, 0);
        chk("burst_tail.wb_dest", 32'(wb_dest), 32'd21);
        drive(0, 0, 0, 0, 0);
        chk("burst_end.busy", 32'(busy), 32'd0);

`ifdef WB_COMMIT_FWD_EN
        // Two pending writes to r7: youngest data must be forwarded.
        drive(0, 1, 7, 32'h10, 0);
        drive(0, 1, 7, 32'h20, 0);
        @(negedge clk);
        in_valid = 1'b0;
        lk_reg = 5'd7;
        #1;
        chk("lk7.hit", 32'(lk_hit), 32'd1);
        chk("lk7.data", lk_data, 32'h20);
        lk_reg = 5'd0;
        #1;
        chk("lk0.hit", 32'(lk_hit), 32'd0);
        lk_reg = 5'd5;
        #1;
        chk("lk5.hit", 32'(lk_hit), 32'd0);
        lk_reg = 5'd7;
        @(posedge clk);
        #1;
        chk("lk7_inflight.hit", 32'(lk_hit), 32'd1);
        chk("lk7_inflight.data", lk_data, 32'h20);
        @(posedge clk);
        #1;
        chk("lk7_idle.hit", 32'(lk_hit), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
